// File: rtl/adder_pkg.sv
// Shared constants and FSM state encoding for the shared-adder arbiter.
package adder_pkg;

  localparam int unsigned ADD_W = 4;
  localparam int unsigned SUM_W = 5;
  localparam int unsigned ID_W  = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/bin_adder.sv
// 4-bit carry look-ahead adder.
module bin_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded from generate/propagate terms rather than rippled.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr.
module rr_grant
  import adder_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx
);

  // Scan offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (req_valid[i] && (i == ((int'(rr_ptr) + k) % int'(NREQ)))) begin
          grant     = '0;
          grant[i]  = 1'b1;
          grant_idx = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one bin_adder among NREQ requesters with round-robin arbitration.
// Operands are registered on accept, the sum is registered one cycle later and
// held on a valid/ready response channel together with the requester id.
module adder_share_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned ADD_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*ADD_W-1:0] req_a,
  input  logic [NREQ*ADD_W-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [1:0]            resp_id,
  output logic [ADD_W:0]        resp_sum,
  output logic [CNT_W-1:0]      done_cnt
);
  import adder_pkg::*;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_next;
  logic [NREQ-1:0]  grant;
  logic [ID_W-1:0]  grant_idx;
  logic             accept;
  logic             complete;
  logic [ADD_W-1:0] sel_a, sel_b;
  logic [ADD_W-1:0] a_q, b_q;
  logic [ID_W-1:0]  id_q;
  logic [ADD_W:0]   sum_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       add_sum;
  logic             add_cout;

  rr_grant #(
    .NREQ (NREQ)
  ) u_rr_grant (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  bin_adder u_bin_adder (
    .a    (a_q),
    .b    (b_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Steer the granted requester's operand pair toward the operand registers.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*ADD_W +: ADD_W];
        sel_b = req_b[i*ADD_W +: ADD_W];
      end
    end
  end

  // Pointer moves to the requester after the one just served.
  always_comb begin
    if (int'(id_q) == int'(NREQ) - 1) begin
      rr_next = '0;
    end else begin
      rr_next = id_q + 1'b1;
    end
  end

  // Next-state and handshake decode; reset masks req_ready so nothing is accepted.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    complete  = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = rst ? '0 : grant;
        if (!rst && (|(req_valid & grant))) begin
          accept  = 1'b1;
          state_d = StAdd;
        end
      end
      StAdd: begin
        state_d = StResp;
      end
      StResp: begin
        if (resp_ready) begin
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture on accept; the id doubles as the response id.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      id_q <= '0;
    end else if (accept) begin
      a_q  <= sel_a;
      b_q  <= sel_b;
      id_q <= grant_idx;
    end
  end

  // Result register, response valid, completion counter and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q    <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else if (state_q == StAdd) begin
      sum_q   <= {add_cout, add_sum};
      valid_q <= 1'b1;
    end else if (complete) begin
      valid_q  <= 1'b0;
      cnt_q    <= cnt_q + 1'b1;
      rr_ptr_q <= rr_next;
    end
  end

  assign resp_valid = valid_q;
  assign resp_id    = id_q;
  assign resp_sum   = sum_q;
  assign done_cnt   = cnt_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with NREQ=2.
module tb_adder_share_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       resp_valid;
  logic       resp_ready;
  logic [1:0] resp_id;
  logic [4:0] resp_sum;
  logic [7:0] done_cnt;

  int vectors;
  int miscompares;
  int exp_done;

  typedef struct {
    logic [1:0] valid;
    logic [7:0] a;
    logic [7:0] b;
    int         id;
    logic [4:0] sum;
  } vec_t;

  vec_t tbl[6];

  adder_share_arbiter #(
    .NREQ  (2),
    .ADD_W (4),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .done_cnt   (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    exp_done = 0;
    #1;
    check("rst_done_cnt", 32'(done_cnt), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_resp_sum", 32'(resp_sum), 32'd0);
  endtask

  // One transaction with resp_ready held high; checks grant, latency, result, count.
  task automatic run_txn(input logic [1:0] valid, input logic [7:0] a, input logic [7:0] b,
                         input int exp_id, input logic [4:0] exp_sum);
    int         cyc;
    logic [1:0] exp_rdy;
    exp_rdy         = '0;
    exp_rdy[exp_id] = 1'b1;
    @(negedge clk);
    req_valid  = valid;
    req_a      = a;
    req_b      = b;
    resp_ready = 1'b1;
    #1;
    cyc = 0;
    while (!(|(req_valid & req_ready)) && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("grant", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    check("add_no_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_id", 32'(resp_id), 32'(exp_id));
    check("resp_sum", 32'(resp_sum), 32'(exp_sum));
    exp_done++;
    @(negedge clk);
    check("resp_cleared", 32'(resp_valid), 32'd0);
    check("done_cnt", 32'(done_cnt), 32'(exp_done % 256));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_done    = 0;
    rst         = 1'b1;
    req_valid   = '0;
    req_a       = '0;
    req_b       = '0;
    resp_ready  = 1'b0;

    // valid, a{a1,a0}, b{b1,b0}, expected id, expected sum
    tbl[0] = '{2'b01, 8'h03, 8'h01, 0, 5'd4};
    tbl[1] = '{2'b10, 8'h30, 8'hA0, 1, 5'd13};
    tbl[2] = '{2'b01, 8'h01, 8'h0F, 0, 5'd16};
    tbl[3] = '{2'b11, 8'hF5, 8'hF6, 1, 5'd30};
    tbl[4] = '{2'b11, 8'h56, 8'h9A, 0, 5'd16};
    tbl[5] = '{2'b11, 8'h56, 8'h9A, 1, 5'd14};

    do_reset();
    for (int v = 0; v < 6; v++) begin
      run_txn(tbl[v].valid, tbl[v].a, tbl[v].b, tbl[v].id, tbl[v].sum);
    end

    // Both requesters held valid from a fresh pointer: grants alternate 0,1,0,1.
    do_reset();
    for (int t = 0; t < 4; t++) begin
      run_txn(2'b11, 8'h22, 8'hFF, t % 2, 5'd17);
    end

    // Backpressure: result held stable and no new accepts while resp_ready is low.
    @(negedge clk);
    req_valid  = 2'b01;
    req_a      = 8'h07;
    req_b      = 8'h08;
    resp_ready = 1'b0;
    #1;
    check("bp_grant", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 2'b11;
    @(negedge clk);
    check("bp_add_ready", 32'(req_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_id", 32'(resp_id), 32'd0);
      check("bp_sum", 32'(resp_sum), 32'd15);
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    exp_done++;
    @(negedge clk);
    check("bp_released", 32'(resp_valid), 32'd0);
    check("bp_done", 32'(done_cnt), 32'(exp_done));
    @(negedge clk);
    check("bp_done_once", 32'(done_cnt), 32'(exp_done));

    // Reset during ADD: leave the pointer at 1 first, then expect it back at 0.
    run_txn(2'b01, 8'h01, 8'h01, 0, 5'd2);
    @(negedge clk);
    req_valid = 2'b10;
    req_a     = 8'h90;
    req_b     = 8'h90;
    #1;
    check("mid_grant", 32'(req_ready), 32'd2);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 2'b11;
    #1;
    check("mid_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    exp_done  = 0;
    repeat (3) begin
      @(negedge clk);
      check("mid_no_resp", 32'(resp_valid), 32'd0);
    end
    check("mid_done", 32'(done_cnt), 32'd0);
    req_valid = 2'b11;
    #1;
    check("mid_rr_ptr0", 32'(req_ready), 32'd1);
    req_valid = '0;

    // Counter wrap: 256 completions bring done_cnt back to 0.
    do_reset();
    for (int n = 0; n < 256; n++) begin
      logic [7:0] nv;
      logic [4:0] s;
      nv = 8'(n);
      s  = {1'b0, nv[3:0]} + {1'b0, nv[7:4]};
      run_txn(2'b01, {4'h0, nv[3:0]}, {4'h0, nv[7:4]}, 0, s);
    end
    check("wrap_done", 32'(done_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
